// File: rtl/conv_mac_sequencer.sv
// Walks one convolution window through the external multiply-add unit, seeding the accumulator with a bias.
// Window latency is KERNEL_SIZE+2 cycles from accepted start to done; start is ignored while busy.
module conv_mac_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 9,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] k_data,
    output logic [DATA_WIDTH-1:0] alu_in,
    output logic [DATA_WIDTH-1:0] alu_k,
    output logic [DATA_WIDTH-1:0] alu_r,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int TW = $clog2(KERNEL_SIZE) + 1;
    localparam logic [TW-1:0] TAP_LAST = TW'(KERNEL_SIZE - 1);
    localparam logic [TW-1:0] TAP_LAST_READ = TW'(KERNEL_SIZE - 2);

    typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [DATA_WIDTH-1:0] result_nxt;
    logic [TW-1:0]         tap_cnt, tap_cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic                  rd_en_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            result  <= '0;
            tap_cnt <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            result  <= result_nxt;
            tap_cnt <= tap_cnt_nxt;
            rd_addr <= rd_addr_nxt;
            rd_en   <= rd_en_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        result_nxt  = result;
        tap_cnt_nxt = tap_cnt;
        rd_addr_nxt = rd_addr;
        rd_en_nxt   = rd_en;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt     = bias_in;
                    rd_addr_nxt = '0;
                    rd_en_nxt   = 1'b1;
                    tap_cnt_nxt = '0;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                rd_addr_nxt = rd_addr + 1'b1;
                state_nxt   = MAC;
            end
            MAC: begin
                acc_nxt     = alu_out;
                tap_cnt_nxt = tap_cnt + 1'b1;
                // Parking the address at 0 once reads stop keeps it inside the buffer range.
                if (tap_cnt == TAP_LAST_READ) begin
                    rd_en_nxt   = 1'b0;
                    rd_addr_nxt = '0;
                end else if (rd_en) begin
                    rd_addr_nxt = rd_addr + 1'b1;
                end
                if (tap_cnt == TAP_LAST) begin
                    result_nxt = alu_out;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign alu_in = (state == MAC) ? in_data : '0;
    assign alu_k  = (state == MAC) ? k_data  : '0;
    assign alu_r  = (state == MAC) ? acc     : '0;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench: synchronous buffer model and a real-valued multiply-add model around the sequencer.
module tb_conv_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bias_in = 32'd0;
    logic        busy, done, rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] in_data = 32'd0;
    logic [31:0] k_data = 32'd0;
    logic [31:0] alu_in, alu_k, alu_r, alu_out, result;

    logic [31:0] in_mem [16];
    logic [31:0] k_mem  [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_mac_sequencer #(.DATA_WIDTH(32), .KERNEL_SIZE(9), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .in_data(in_data), .k_data(k_data),
        .alu_in(alu_in), .alu_k(alu_k), .alu_r(alu_r), .alu_out(alu_out),
        .result(result)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= in_mem[rd_addr];
            k_data  <= k_mem[rd_addr];
        end
    end

    function automatic real sp2real(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return real2sp(sp2real(a) * sp2real(b) + sp2real(c));
    endfunction

    assign alu_out = fmac(alu_in, alu_k, alu_r);

    task automatic fill(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 16; i++) begin
            in_mem[i] = a;
            k_mem[i]  = b;
        end
    endtask

    // Starts a window from IDLE and follows it until done; leaves the DUT back in IDLE.
    task automatic run_window(input logic [31:0] bias, output int lat, output logic [31:0] res,
                              output int ren_cnt, output int addr_err);
        lat = 0;
        res = 32'hDEAD_BEEF;
        ren_cnt = 0;
        addr_err = 0;
        bias_in = bias;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (rd_en) begin
                if (rd_addr != ren_cnt[3:0]) addr_err++;
                ren_cnt++;
            end
            if (done) begin
                lat = n;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done, rd_en} !== 3'b000) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: busy/done/rd_en=%b expected 000", n, {busy, done, rd_en});
            end
            checks++;
            if (result !== 32'd0 || rd_addr !== 4'd0) begin
                errors++;
                $display("FAIL reset_regs cycle %0d: result=%h rd_addr=%0d expected 0/0", n, result, rd_addr);
            end
            checks++;
            if ((alu_in | alu_k | alu_r) !== 32'd0) begin
                errors++;
                $display("FAIL reset_alu cycle %0d: alu_in=%h alu_k=%h alu_r=%h expected 0", n, alu_in, alu_k, alu_r);
            end
        end
    endtask

    task automatic test_unit_sum;
        int lat, rc, ae;
        logic [31:0] res;
        fill(32'h3F80_0000, 32'h3F80_0000);
        run_window(32'd0, lat, res, rc, ae);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL unit_latency: got %0d expected 11", lat);
        end
        checks++;
        if (res !== 32'h4110_0000) begin
            errors++;
            $display("FAIL unit_result: got %h expected 41100000", res);
        end
        checks++;
        if (rc !== 9 || ae !== 0) begin
            errors++;
            $display("FAIL unit_reads: rd_en cycles %0d addr errors %0d expected 9/0", rc, ae);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL unit_after_done: busy=%b done=%b expected 0/0", busy, done);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h4110_0000) begin
            errors++;
            $display("FAIL unit_hold: result=%h expected 41100000", result);
        end
    endtask

    task automatic test_bias_scale;
        int lat, rc, ae;
        logic [31:0] res;
        fill(32'h4000_0000, 32'h3F00_0000);
        run_window(32'h3F00_0000, lat, res, rc, ae);
        checks++;
        if (res !== 32'h4118_0000 || lat !== 11) begin
            errors++;
            $display("FAIL bias_scale: result=%h lat=%0d expected 41180000/11", res, lat);
        end
    endtask

    task automatic test_negative;
        int lat, rc, ae;
        logic [31:0] res;
        fill(32'hBF80_0000, 32'h3F80_0000);
        run_window(32'd0, lat, res, rc, ae);
        checks++;
        if (res !== 32'hC110_0000 || lat !== 11) begin
            errors++;
            $display("FAIL negative: result=%h lat=%0d expected c1100000/11", res, lat);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int dcyc [4];
        fill(32'h3F80_0000, 32'h3F80_0000);
        bias_in = 32'd0;
        pulses = 0;
        for (int i = 0; i < 4; i++) dcyc[i] = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                if (pulses < 4) dcyc[pulses] = n;
                pulses++;
                checks++;
                if (result !== 32'h4110_0000) begin
                    errors++;
                    $display("FAIL b2b_result: pulse %0d result=%h expected 41100000", pulses, result);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (pulses !== 3 || dcyc[0] !== 11 || dcyc[1] !== 23 || dcyc[2] !== 35) begin
            errors++;
            $display("FAIL b2b_timing: pulses=%0d at %0d,%0d,%0d expected 3 at 11,23,35",
                     pulses, dcyc[0], dcyc[1], dcyc[2]);
        end
        for (int n = 0; n < 30 && busy; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_busy_ignore;
        int pulses, first;
        fill(32'h3F80_0000, 32'h3F80_0000);
        bias_in = 32'd0;
        pulses = 0;
        first = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 30; n++) begin
            start = (n == 3 || n == 6 || n == 9 || n == 11);
            if (n == 11) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_done: busy=%b expected 1", busy);
                end
            end
            if (done) begin
                pulses++;
                if (first == 0) first = n;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1 || first !== 11) begin
            errors++;
            $display("FAIL busy_ignore: pulses=%0d first=%0d expected 1/11", pulses, first);
        end
    endtask

    task automatic test_reset_mid;
        int lat, rc, ae, pulses;
        logic [31:0] res;
        fill(32'h4000_0000, 32'h3F00_0000);
        bias_in = 32'h3F00_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (alu_r === 32'd0 || rd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_before_reset: alu_r=%h rd_en=%b expected nonzero/1", alu_r, rd_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, rd_en} !== 3'b000 || rd_addr !== 4'd0 || result !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy/done/rd_en=%b rd_addr=%0d result=%h expected 000/0/0",
                     {busy, done, rd_en}, rd_addr, result);
        end
        checks++;
        if ((alu_in | alu_k | alu_r) !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_alu: alu_in=%h alu_k=%h alu_r=%h expected 0", alu_in, alu_k, alu_r);
        end
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: %0d busy/done cycles expected 0", pulses);
        end
        run_window(32'h3F00_0000, lat, res, rc, ae);
        checks++;
        if (res !== 32'h4118_0000 || lat !== 11 || rc !== 9 || ae !== 0) begin
            errors++;
            $display("FAIL mid_recover: result=%h lat=%0d reads=%0d addr_err=%0d expected 41180000/11/9/0",
                     res, lat, rc, ae);
        end
    endtask

    initial begin
        test_reset();
        test_unit_sum();
        test_bias_scale();
        test_negative();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_mac_sequencer.md
Name: conv_mac_sequencer

Overview:
Sequences one convolution window through the shared single-precision multiply-add unit (out = in*k + r). It fetches KERNEL_SIZE input/weight pairs from synchronous buffers and feeds them to the unit, accumulating through a feedback register seeded with a bias. It presents the final IEEE-754 sum with a one-cycle done pulse. It sits between the window/weight buffers and the MAC datapath in the convolution engine.

Parameters:
DATA_WIDTH, 32, operand/result width (IEEE-754 single bit patterns, never interpreted by this block)
KERNEL_SIZE, 9, taps per window (>=2)
ADDR_WIDTH, 4, buffer address width; 2**ADDR_WIDTH >= KERNEL_SIZE

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin a window; sampled only in IDLE
bias_in  in  DATA_WIDTH  initial accumulator value, latched on accepted start
busy  out  1  high in FETCH, MAC, DONE
done  out  1  one-cycle pulse, result valid
rd_en  out  1  buffer read enable
rd_addr  out  ADDR_WIDTH  tap address to input and weight buffers
in_data  in  DATA_WIDTH  input sample, valid one cycle after rd_addr/rd_en
k_data  in  DATA_WIDTH  weight, same timing as in_data
alu_in  out  DATA_WIDTH  to MAC unit operand a
alu_k  out  DATA_WIDTH  to MAC unit operand b
alu_r  out  DATA_WIDTH  to MAC unit addend
alu_out  in  DATA_WIDTH  from MAC unit, combinational
result  out  DATA_WIDTH  final accumulated sum

Behaviour:
- Reset: state=IDLE; busy=0, done=0, rd_en=0, rd_addr=0, tap_cnt=0, acc=0, result=0. Reset at any state aborts the window; no done pulse, result cleared.
- FSM states IDLE, FETCH, MAC, DONE; all state and registers update on rising clk.
- IDLE: start=1 -> acc<=bias_in, rd_addr<=0, rd_en<=1, tap_cnt<=0, go FETCH. start=0 -> stay.
- FETCH (1 cycle): buffer is reading addr 0; rd_addr<=1; rd_en stays 1; go MAC.
- MAC (KERNEL_SIZE cycles): alu_in=in_data, alu_k=k_data, alu_r=acc (combinational). Each cycle: acc<=alu_out, tap_cnt<=tap_cnt+1, rd_addr<=rd_addr+1. While tap_cnt==KERNEL_SIZE-2, rd_en<=0, so the last read is address KERNEL_SIZE-1. While tap_cnt==KERNEL_SIZE-1, acc<=alu_out, go DONE.
- Outside MAC: alu_in, alu_k and alu_r are driven 0.
- DONE (1 cycle): done=1, result<=acc in the same edge that leaves DONE? No: result is registered on entry to DONE, i.e. result<=alu_out on the final MAC edge. done and result are therefore valid together in DONE. The next state is IDLE.
- Latency: if start is sampled at edge E0, FETCH occupies cycle 1, MAC occupies cycles 2..K+1, and done is high in cycle K+2 (11 for K=9). Back-to-back windows: the earliest accepted start is the edge leaving IDLE after DONE, giving throughput K+3 cycles per window.
- result holds its value until the next window completes or a reset occurs.
- A start asserted while busy is ignored; no queuing.
- No arithmetic is done in this block. Rounding and exception behaviour belong to the MAC unit. acc passes bit patterns through unchanged.
- tap_cnt is clog2(KERNEL_SIZE)+1 bits wide. rd_addr is never driven beyond KERNEL_SIZE-1 while rd_en=1.

Test Plan:
- Reset then idle: rst held 2 cycles, start=0 for 20 cycles -> busy=done=rd_en=0, result=0, alu_* = 0.
- Unit sum: in=1.0 (0x3F800000), k=1.0 for all taps, bias=0 -> done at cycle 11 after start, result=0x41100000 (9.0). rd_addr sequence 0..8, rd_en high exactly 9 cycles.
- Bias plus scaling: in=2.0 (0x40000000), k=0.5 (0x3F000000), bias=0.5 (0x3F000000) -> result=0x41180000 (9.5).
- Negative operands: in=-1.0 (0xBF800000), k=1.0, bias=0 -> result=0xC1100000 (-9.0).
- start held high continuously -> windows complete every 12 cycles. start pulses during busy are ignored, with no extra done pulses.
- rst asserted in MAC at tap 4 -> next cycle state IDLE, all outputs 0, no done. A fresh start then produces a correct full window.
